imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
// - Parametrised, handshaked immediate extender for the MIPS datapath (decode -> execute).
// - Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes.
// - Modes: sign-extend, zero-extend, upper (LUI) and branch-offset (sign-extend, <<2).
// - Registered output behind a 2-entry skid buffer: full throughput under back-pressure, no data loss.
// PARAMETERS
// - IN_W    16  immediate width; >= 2
// - OUT_W   32  result width; must satisfy OUT_W >= IN_W + 2
// PORTS
// - clk        in   1      clock; all state updates on posedge
// - rst        in   1      synchronous reset, active-high
// - in_valid   in   1      upstream has an immediate this cycle
// - in_ready   out  1      block can accept; transfer when in_valid && in_ready
// - in_mode    in   2      00 sign, 01 zero, 10 upper, 11 branch
// - in_data    in   IN_W   immediate field
// - out_valid  out  1      out_data holds a result
// - out_ready  in   1      downstream accepts; transfer when out_valid && out_ready
// - out_data   out  OUT_W  extended result
// BEHAVIOUR
// - One clock (clk); reset synchronous, active-high (rst).
// - Reset: state EMPTY, out_valid=0, out_data=0, skid register=0.
// - in_ready is 0 while rst is high, 1 on the first cycle after rst deasserts.
// - Reset mid-operation: all buffered results are discarded; no result may appear after reset.
// - Extension (combinational on accept, then registered); s = in_data[IN_W-1]:
//   - 00: {(OUT_W-IN_W){s}, in_data}.
//   - 01: {(OUT_W-IN_W){1'b0}, in_data}.
//   - 10: in_data << (OUT_W-IN_W); low bits zero.
//   - 11: sign-extended value << 2; bits shifted out above OUT_W are dropped.
// - Latency: an input accepted at edge N is visible on out_data after edge N
//   (out_valid=1 on cycle N+1) when the output register is free.
// - Storage: output register (OR) plus one skid register (SK).
// - States:
//   - EMPTY: out_valid=0, in_ready=1.
//   - ONE: OR valid, SK empty, in_ready=1.
//   - FULL: OR and SK valid, in_ready=0.
// - Transitions; acc = in_valid&&in_ready, dq = out_valid&&out_ready:
//   - EMPTY: acc -> ONE (OR<=new); else EMPTY.
//   - ONE: acc&&dq -> ONE (OR<=new); acc&&!dq -> FULL (SK<=new);
//     !acc&&dq -> EMPTY; else ONE.
//   - FULL: dq -> ONE (OR<=SK); else FULL. No accept possible.
// - in_ready is a function of registered state only; no in_valid->in_ready or
//   out_ready->in_ready combinational path.
// - out_data and out_valid are register outputs.
// - out_data holds its value while out_valid && !out_ready (AXI-style stability).
// - Ordering strictly FIFO; every accepted input produces exactly one output.
// - in_mode and in_data are sampled only on an accept; ignored otherwise.
// - out_data keeps its last value when out_valid=0 (not cleared, except by reset).
// TESTING
// - Sign: out_ready=1, mode 00, 0x14CB -> 0x000014CB; then 0xFEBD (-323) -> 0xFFFFFEBD;
//   each appears one cycle after accept.
// - Zero/upper/branch: 01,0xFEBD -> 0x0000FEBD; 10,0x1234 -> 0x12340000;
//   11,0xFFFF -> 0xFFFFFFFC; 11,0x0004 -> 0x00000010.
// - Back-pressure: out_ready=0, in_valid=1 with 0x0001,0x0002,0x0003 -> first two accepted,
//   in_ready=0 from 3rd cycle; out_data stable 0x00000001; release out_ready ->
//   outputs 1,2,3 in order, no loss or duplication.
// - Streaming: out_ready=1, 100 back-to-back random inputs -> one output per cycle,
//   in_ready never drops; results match a reference model.
// - Reset mid-operation: reach FULL, assert rst one cycle -> out_valid=0, out_data=0;
//   in_ready=1 after release; no stale result emerges.
// - Param: IN_W=12, OUT_W=16, mode 00, 0x800 -> 0xF800; mode 11 -> 0xE000 (overflow bit dropped).

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: handshaked immediate extender (decode -> execute).
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_mode/in_data
//        upstream; out_valid/out_ready/out_data downstream.
//        in_mode: 00 sign, 01 zero, 10 upper, 11 branch (sign-ext << 2).
//        Output register plus one skid register: full rate under stall.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int PAD = OUT_W - IN_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [OUT_W-1:0] res_q;
    logic [OUT_W-1:0] skid_q;
    logic             valid_q;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic             acc;
    logic             dq;

    always_comb begin
        sext = {{PAD{in_data[IN_W-1]}}, in_data};
        ext  = sext;
        case (in_mode)
            2'b00: ext = sext;
            2'b01: ext = {{PAD{1'b0}}, in_data};
            2'b10: ext = {in_data, {PAD{1'b0}}};
            2'b11: ext = sext << 2;
            default: ext = sext;
        endcase
    end

    // Ready depends only on registered state (and reset), never on
    // in_valid or out_ready.
    assign in_ready  = !rst && (state != FULL);
    assign acc       = in_valid && in_ready;
    assign dq        = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_data  = res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            res_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        res_q   <= ext;
                        valid_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (acc && dq) begin
                        res_q <= ext;
                    end else if (acc) begin
                        // Output stalled: park the new result in the skid.
                        skid_q <= ext;
                        state  <= FULL;
                    end else if (dq) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    if (dq) begin
                        res_q <= skid_q;
                        state <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed literal checks plus randomized traffic
// compared against a queue-based reference model of imm_extend_pipe.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'b00;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    logic        p_in_valid = 1'b0;
    logic        p_in_ready;
    logic [1:0]  p_in_mode = 2'b00;
    logic [11:0] p_in_data = '0;
    logic        p_out_valid;
    logic        p_out_ready = 1'b1;
    logic [15:0] p_out_data;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q[$];
    logic [15:0] pq[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(16)) dut_p (
        .clk(clk), .rst(rst),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_mode(p_in_mode), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_data(p_out_data)
    );

    // Arithmetic reference: interpret the immediate as a number and scale.
    function automatic longint unsigned ref_ext(input int mode,
        input longint unsigned d, input int iw, input int ow);
        longint sv;
        longint m;
        m  = (longint'(1) << ow) - 1;
        sv = longint'(d);
        if (d >= (longint'(1) << (iw - 1)))
            sv = sv - (longint'(1) << iw);
        case (mode)
            0: return longint'(sv & m);
            1: return d;
            2: return longint'((d * (longint'(1) << (ow - iw))) & m);
            default: return longint'((sv * 4) & m);
        endcase
    endfunction

    task automatic chk(input string nm, input longint unsigned act,
                       input longint unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [15:0] d,
                        input logic [31:0] exp, input string nm);
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        chk({nm, "_rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_vld"}, out_valid, 1);
        chk(nm, out_data, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        bit dq;
        repeat (2) @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_p_vld", p_out_valid, 0);
        rst = 1'b0;
        #1;
        chk("rel_rdy", in_ready, 1);

        out_ready = 1'b1;
        send(2'b00, 16'h14CB, 32'h000014CB, "sign_pos");
        send(2'b00, 16'hFEBD, 32'hFFFFFEBD, "sign_neg");
        send(2'b01, 16'hFEBD, 32'h0000FEBD, "zero");
        send(2'b10, 16'h1234, 32'h12340000, "upper");
        send(2'b11, 16'hFFFF, 32'hFFFFFFFC, "branch_neg");
        send(2'b11, 16'h0004, 32'h00000010, "branch_pos");

        // Back-pressure: two accepted, third held off.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b01;
        in_data   = 16'h0001;
        chk("bp_rdy0", in_ready, 1);
        @(negedge clk);
        in_data = 16'h0002;
        chk("bp_rdy1", in_ready, 1);
        chk("bp_d1", out_data, 32'h1);
        @(negedge clk);
        in_data = 16'h0003;
        chk("bp_full_rdy", in_ready, 0);
        chk("bp_vld", out_valid, 1);
        chk("bp_hold", out_data, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_rdy", in_ready, 0);
            chk("bp_stall_data", out_data, 32'h1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out2", out_data, 32'h2);
        chk("bp_rdy_back", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_out3_vld", out_valid, 1);
        chk("bp_out3", out_data, 32'h3);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);
        chk("bp_keep", out_data, 32'h3);

        // Reset with both registers occupied.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b01;
        in_data   = 16'h0055;
        @(negedge clk);
        in_data = 16'h0066;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_full", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_vld", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_rdy", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("mr_rel_rdy", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mr_no_stale", out_valid, 0);
        end

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("st_vld", out_valid, 1);
                chk("st_data", out_data, q.pop_front());
            end
            chk("st_rdy", in_ready, 1);
            in_valid = 1'b1;
            in_mode  = 2'($urandom);
            in_data  = 16'($urandom);
            q.push_back(32'(ref_ext(int'(in_mode), in_data, 16, 32)));
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("st_last", out_data, q.pop_front());

        // Random valid/ready traffic, then a forced drain.
        for (int i = 0; i < 404; i++) begin
            @(negedge clk);
            chk("rn_vld", out_valid, q.size() > 0);
            if (q.size() > 0)
                chk("rn_data", out_data, q[0]);
            chk("rn_rdy", in_ready, q.size() < 2);
            if (i < 400) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in_mode = 2'($urandom);
            in_data = 16'($urandom);
            acc = in_valid && in_ready;
            dq  = out_valid && out_ready;
            @(posedge clk);
            if (dq)
                void'(q.pop_front());
            if (acc)
                q.push_back(32'(ref_ext(int'(in_mode), in_data, 16, 32)));
        end
        @(negedge clk);
        chk("rn_empty", out_valid, 0);

        // Narrow instance: 12 -> 16 bits.
        @(negedge clk);
        p_in_valid = 1'b1;
        p_in_mode  = 2'b00;
        p_in_data  = 12'h800;
        chk("p_rdy", p_in_ready, 1);
        @(negedge clk);
        chk("p_sign", p_out_data, 16'hF800);
        p_in_mode = 2'b11;
        @(negedge clk);
        p_in_valid = 1'b0;
        chk("p_branch", p_out_data, 16'hE000);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("p_st_vld", p_out_valid, 1);
                chk("p_st_data", p_out_data, pq.pop_front());
            end
            p_in_valid = 1'b1;
            p_in_mode  = 2'($urandom);
            p_in_data  = 12'($urandom);
            pq.push_back(16'(ref_ext(int'(p_in_mode), p_in_data, 12, 16)));
        end
        @(negedge clk);
        p_in_valid = 1'b0;
        chk("p_last", p_out_data, pq.pop_front());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
